// File: rtl/elevator_call_register.sv
// elevator_call_register: hall/car button front end for the 3-floor elevator
// controller. Each raw button is synchronised, debounced and turned into a
// sticky request that holds until the controller stops with its door open at
// the request's floor.
// Optional build macro SVC_COUNT_EN adds a saturating service-event counter
// (svc_count) with a synchronous clear (svc_count_clr).
module elevator_call_register #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] btn_raw,
    input  logic [1:0] current_flr,
    input  logic       is_door_close,
    input  logic       is_moving,
`ifdef SVC_COUNT_EN
    input  logic       svc_count_clr,
    output logic [7:0] svc_count,
`endif
    output logic [6:0] pending,
    output logic       any_pending,
    output logic       svc_pulse
);

    localparam int unsigned      NB       = 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    sync1_q, sync2_q;
    logic [NB-1:0]    stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    press_q, press_d;
    logic [NB-1:0]    pending_q, pending_d;
    logic             any_pending_q;
    logic             svc_pulse_q, svc_pulse_d;
    logic [NB-1:0]    clr_mask;

    // Two-flop synchroniser on every raw button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: stable flips after DEBOUNCE_CYCLES consecutive differing edges;
    // a 0->1 flip is flagged as a press for the following cycle.
    always_comb begin
        stable_d = stable_q;
        press_d  = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    press_d[i]  = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state, counters and press register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            press_q  <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int unsigned i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Service clear mask and next request state; a clear beats a same-cycle press.
    always_comb begin
        clr_mask = '0;
        if (!is_door_close && !is_moving) begin
            unique case (current_flr)
                2'd0:    clr_mask = 7'b0010001;
                2'd1:    clr_mask = 7'b0100110;
                2'd2:    clr_mask = 7'b1001000;
                default: clr_mask = '0;
            endcase
        end
        pending_d   = (pending_q | press_q) & ~clr_mask;
        svc_pulse_d = |(pending_q & clr_mask);
    end

    // Request, summary and service-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= '0;
            any_pending_q <= 1'b0;
            svc_pulse_q   <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            any_pending_q <= |pending_d;
            svc_pulse_q   <= svc_pulse_d;
        end
    end

    assign pending     = pending_q;
    assign any_pending = any_pending_q;
    assign svc_pulse   = svc_pulse_q;

`ifdef SVC_COUNT_EN
    logic [7:0] svc_count_q;

    // Counts service events, saturating at 255; counting on the same edge that
    // raises svc_pulse lets a clear issued alongside a service leave zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            svc_count_q <= '0;
        end else if (svc_count_clr) begin
            svc_count_q <= '0;
        end else if (svc_pulse_d && (svc_count_q != 8'hFF)) begin
            svc_count_q <= svc_count_q + 8'd1;
        end
    end

    assign svc_count = svc_count_q;
`endif

endmodule

// File: tb/tb_elevator_call_register.sv
// Self-checking bench for elevator_call_register: a window-based behavioural
// model checked every cycle, plus literal expectations at key points.
module tb_elevator_call_register;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] btn_raw = '0;
    logic [1:0] current_flr = '0;
    logic       is_door_close = 1'b1;
    logic       is_moving = 1'b0;
    logic [6:0] pending;
    logic       any_pending;
    logic       svc_pulse;
`ifdef SVC_COUNT_EN
    logic       svc_count_clr = 1'b0;
    logic [7:0] svc_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    elevator_call_register #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .current_flr(current_flr),
        .is_door_close(is_door_close),
        .is_moving(is_moving),
`ifdef SVC_COUNT_EN
        .svc_count_clr(svc_count_clr),
        .svc_count(svc_count),
`endif
        .pending(pending),
        .any_pending(any_pending),
        .svc_pulse(svc_pulse)
    );

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Behavioural model: the button's synchronised view is its raw value two
    // edges old; a debounced state flips once the last D synchronised samples
    // all disagree with it. Each button belongs to one floor.
    int         floor_of [7] = '{0, 1, 1, 2, 0, 1, 2};
    logic [6:0] m_h1, m_h2, m_stable, m_press, m_pend;
    logic       m_any, m_pulse;
    int         m_count;
    logic [6:0] m_win [$];

    always @(posedge clk or posedge rst) begin
        logic [6:0] flips;
        logic [6:0] clr;
        logic [6:0] newp;
        logic       hit;
        logic       all_diff;
        if (rst) begin
            m_h1 <= '0; m_h2 <= '0; m_stable <= '0; m_press <= '0;
            m_pend <= '0; m_any <= 1'b0; m_pulse <= 1'b0; m_count <= 0;
            m_win.delete();
        end else begin
            m_win.push_back(m_h2);
            if (m_win.size() > D) void'(m_win.pop_front());
            flips = '0;
            for (int b = 0; b < 7; b++) begin
                all_diff = (m_win.size() == D);
                foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) all_diff = 1'b0;
                flips[b] = all_diff;
            end
            clr = '0;
            if (!is_door_close && !is_moving)
                for (int b = 0; b < 7; b++)
                    if (int'(current_flr) == floor_of[b]) clr[b] = 1'b1;
            hit  = |(m_pend & clr);
            newp = (m_pend | m_press) & ~clr;
            m_pend  <= newp;
            m_any   <= |newp;
            m_pulse <= hit;
`ifdef SVC_COUNT_EN
            if (svc_count_clr) m_count <= 0;
            else if (hit && m_count < 255) m_count <= m_count + 1;
`endif
            m_press  <= flips & ~m_stable;
            m_stable <= m_stable ^ flips;
            m_h2 <= m_h1;
            m_h1 <= btn_raw;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("pending_vs_model", 32'(pending), 32'(m_pend));
        check("any_pending_vs_model", 32'(any_pending), 32'(m_any));
        check("svc_pulse_vs_model", 32'(svc_pulse), 32'(m_pulse));
`ifdef SVC_COUNT_EN
        check("svc_count_vs_model", 32'(svc_count), 32'(m_count));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random buttons
        rst = 1'b1;
        btn_raw = 7'($urandom);
        step(3);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_any", 32'(any_pending), 32'h0);
        check("rst_pulse", 32'(svc_pulse), 32'h0);
        rst = 1'b0;
        btn_raw = '0;
        step(20);
        check("idle_pending", 32'(pending), 32'h0);
        check("idle_any", 32'(any_pending), 32'h0);

        // Clean press of go_to_second_flr, then service at floor 2
        is_door_close = 1'b1; current_flr = 2'd0; is_moving = 1'b0;
        btn_raw = 7'b1000000;
        step(6);
        check("latency_edge6", 32'(pending), 32'h0);
        step(1);
        check("latency_edge7", 32'(pending), 32'b1000000);
        check("latency_any", 32'(any_pending), 32'h1);
        step(3);
        btn_raw = '0;
        step(10);
        check("held_after_release", 32'(pending), 32'b1000000);
        current_flr = 2'd2; is_door_close = 1'b0;
        step(1);
        check("serve_f2_pending", 32'(pending), 32'h0);
        check("serve_f2_pulse", 32'(svc_pulse), 32'h1);
        step(1);
        check("serve_f2_pulse_once", 32'(svc_pulse), 32'h0);
        is_door_close = 1'b1; current_flr = 2'd0;

        // Bounce rejection
        for (int i = 0; i < 12; i++) begin
            btn_raw[1] = ~btn_raw[1];
            step(1);
        end
        btn_raw = '0;
        step(8);
        check("bounce_toggle", 32'(pending), 32'h0);
        btn_raw[1] = 1'b1;
        step(3);
        btn_raw = '0;
        step(8);
        check("bounce_short", 32'(pending), 32'h0);

        // Floor mask
        btn_raw = 7'b0100111;
        step(8);
        btn_raw = '0;
        step(8);
        check("mask_set", 32'(pending), 32'b0100111);
        current_flr = 2'd1; is_door_close = 1'b0;
        step(1);
        check("mask_f1", 32'(pending), 32'b0000001);
        check("mask_f1_pulse", 32'(svc_pulse), 32'h1);
        is_door_close = 1'b1;
        step(1);
        current_flr = 2'd3; is_door_close = 1'b0;
        step(1);
        check("mask_f3", 32'(pending), 32'b0000001);
        check("mask_f3_pulse", 32'(svc_pulse), 32'h0);
        step(2);
        check("mask_f3_hold", 32'(pending), 32'b0000001);
        current_flr = 2'd0;
        step(1);
        check("mask_f0", 32'(pending), 32'h0);

        // Press while door open at own floor is dropped; door closed it latches
        btn_raw[4] = 1'b1;
        step(10);
        btn_raw = '0;
        step(8);
        check("press_vs_clear", 32'(pending), 32'h0);
        is_door_close = 1'b1;
        btn_raw[4] = 1'b1;
        step(10);
        btn_raw = '0;
        step(8);
        check("press_door_closed", 32'(pending), 32'b0010000);
        is_door_close = 1'b0;
        step(1);
        check("press_serve", 32'(pending), 32'h0);
        is_door_close = 1'b1;

        // Moving blocks service
        btn_raw[3] = 1'b1;
        step(8);
        btn_raw = '0;
        current_flr = 2'd2; is_door_close = 1'b0; is_moving = 1'b1;
        step(8);
        check("moving_blocks", 32'(pending), 32'b0001000);
        is_moving = 1'b0;
        step(1);
        check("moving_release", 32'(pending), 32'h0);
        is_door_close = 1'b1; current_flr = 2'd0;

        // Random stretch checked by the model
        for (int i = 0; i < 40; i++) begin
            btn_raw       = 7'($urandom);
            current_flr   = 2'($urandom);
            is_door_close = 1'($urandom);
            is_moving     = ($urandom_range(0, 3) == 0);
            step(8);
        end

        // Asynchronous reset mid-operation
        btn_raw = 7'b1111111; is_door_close = 1'b1; is_moving = 1'b0;
        step(12);
        check("all_pending", 32'(pending), 32'b1111111);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_pending", 32'(pending), 32'h0);
        check("async_rst_any", 32'(any_pending), 32'h0);
        step(2);
        rst = 1'b0;
        btn_raw = '0;
        step(12);
        check("post_rst_pending", 32'(pending), 32'h0);

`ifdef SVC_COUNT_EN
        // Counter saturation and clear priority
        current_flr = 2'd0;
        for (int i = 0; i < 300; i++) begin
            btn_raw = 7'b0000001;
            step(7);
            btn_raw = '0;
            is_door_close = 1'b0;
            step(1);
            is_door_close = 1'b1;
            step(8);
        end
        check("count_saturate", 32'(svc_count), 32'd255);
        btn_raw = 7'b0000001;
        step(7);
        btn_raw = '0;
        is_door_close = 1'b0;
        svc_count_clr = 1'b1;
        step(1);
        check("count_clr_value", 32'(svc_count), 32'd0);
        check("count_clr_pulse", 32'(svc_pulse), 32'h1);
        svc_count_clr = 1'b0;
        is_door_close = 1'b1;
        step(8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
